activity_detect: RTL

- Upstream feeder for the board activity LEDs.
- Monitors up to N_SRC raw activity lines (SPI chip-selects, bus requests, UART RX, etc.), which may be asynchronous. Each line is synchronised and edge-detected, then masked.
- Produces rate-limited single-cycle activity pulses for the LED visualizer stage.
- Keeps a saturating event counter with a sticky overflow flag for debug readout.

---
 rtl/activity_detect.sv | 112 +++++++++++
 1 files changed

// File: rtl/activity_detect.sv
// Synchronises and edge-detects raw activity lines, emits rate-limited activity pulses for
// the LED visualizer and keeps a saturating debug event counter with sticky overflow.
module activity_detect #(
  parameter int N_SRC   = 4,
  parameter int MIN_GAP = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [N_SRC-1:0] mask,
  input  logic             clear,
  output logic             activity,
  output logic [CNT_W-1:0] event_count,
  output logic             overflow
);

  localparam int GAP_W = $clog2(MIN_GAP) + 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] HOLDOFF = 1'b1;

  logic [N_SRC-1:0] s1_q, s2_q, s3_q;
  logic [N_SRC-1:0] edges;
  logic             any_edge;

  logic [0:0]       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pend_q, pend_d;
  logic             act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;

  // Mask after edge detection so unmasking an already-high line yields no edge.
  assign edges    = s2_q & ~s3_q & mask;
  assign any_edge = |edges;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    act_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_edge) begin
          act_d   = 1'b1;
          gap_d   = GAP_RELOAD;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (any_edge) pend_d = 1'b1;
        if (gap_q == '0) begin
          if (pend_q || any_edge) begin
            act_d  = 1'b1;
            gap_d  = GAP_RELOAD;
            pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear drops the deferred event but never suppresses a pulse already due.
    if (clear) pend_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    ov_d  = ov_q;
    if (clear) begin
      cnt_d = '0;
      ov_d  = 1'b0;
    end else if (any_edge) begin
      if (&cnt_q) ov_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      state_q <= IDLE;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      act_q   <= 1'b0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      s1_q    <= src;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

  assign activity    = act_q;
  assign event_count = cnt_q;
  assign overflow    = ov_q;

endmodule
